// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the five-stage pipeline datapath and its
// central sequencer. The pipeline side (master) reports stage status and
// receives register enables/clears; the sequencer (slave) does the reverse.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  // Stage status from the datapath
  logic [REG_ADDR_W-1:0] ID_Rs;
  logic [REG_ADDR_W-1:0] ID_Rt;
  logic                  ID_UsesRs;
  logic                  ID_UsesRt;
  logic [REG_ADDR_W-1:0] EX_Dest;
  logic                  EX_IsLoad;
  logic                  MEM_IsBranch;
  logic                  MEM_Condition;
  logic                  MEM_Req;
  logic                  MEM_Ready;

  // Pipeline-register controls back to the datapath
  logic                  PC_En;
  logic                  PC_SelBranch;
  logic                  IFID_En;
  logic                  IDEX_En;
  logic                  EXMEM_En;
  logic                  MEMWB_En;
  logic                  IFID_Clr;
  logic                  IDEX_Clr;
  logic                  EXMEM_Clr;
  logic                  MEMWB_Clr;

  // Status and performance counters
  logic                  MemTimeout;
  logic [CNT_W-1:0]      StallCount;
  logic [CNT_W-1:0]      FlushCount;
  logic [1:0]            State;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, EX_Dest, EX_IsLoad,
           MEM_IsBranch, MEM_Condition, MEM_Req, MEM_Ready,
    input  PC_En, PC_SelBranch, IFID_En, IDEX_En, EXMEM_En, MEMWB_En,
           IFID_Clr, IDEX_Clr, EXMEM_Clr, MEMWB_Clr,
           MemTimeout, StallCount, FlushCount, State
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, EX_Dest, EX_IsLoad,
           MEM_IsBranch, MEM_Condition, MEM_Req, MEM_Ready,
    output PC_En, PC_SelBranch, IFID_En, IDEX_En, EXMEM_En, MEMWB_En,
           IFID_Clr, IDEX_Clr, EXMEM_Clr, MEMWB_Clr,
           MemTimeout, StallCount, FlushCount, State
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the five-stage pipeline. Control outputs are
// Mealy (same-cycle) from the registered state and the stage status inputs.
// Priority: memory-wait freeze > taken-branch flush > load-use stall.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16,
  parameter int WAIT_MAX   = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WC_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01
  } state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic memwait, taken, loaduse, freeze;
  logic stall_inc, flush_inc;

  logic pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_clr, idex_clr, exmem_clr, memwb_clr;

  // Saturating increment for the performance counters: never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign memwait = hz.MEM_Req & ~hz.MEM_Ready;
  assign taken   = hz.MEM_IsBranch & hz.MEM_Condition;
  assign loaduse = hz.EX_IsLoad & (hz.EX_Dest != '0) &
                   ((hz.ID_UsesRs & (hz.ID_Rs == hz.EX_Dest)) |
                    (hz.ID_UsesRt & (hz.ID_Rt == hz.EX_Dest)));

  // In RUN a new memory wait freezes; in MEM_WAIT the freeze holds until Ready.
  assign freeze = (state_q == MEM_WAIT) ? ~hz.MEM_Ready : memwait;

  // Next-state and same-cycle pipeline controls, highest-priority hazard wins.
  always_comb begin
    pc_en     = 1'b1;
    pc_sel    = 1'b0;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    memwb_clr = 1'b0;
    state_d   = state_q;
    wait_d    = wait_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (freeze) begin
      // Hold everything upstream of MEM; WB receives a bubble.
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_clr = 1'b1;
      stall_inc = 1'b1;
      state_d   = MEM_WAIT;
      if (state_q == RUN) begin
        wait_d = WC_W'(1);
      end else if (wait_q != WAIT_LIM) begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      // Release (or no wait): branch/load-use resolution applies this cycle.
      state_d = RUN;
      if (taken) begin
        pc_sel    = 1'b1;
        ifid_clr  = 1'b1;
        idex_clr  = 1'b1;
        exmem_clr = 1'b1;
        flush_inc = 1'b1;
      end else if (loaduse) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_clr  = 1'b1;
        stall_inc = 1'b1;
      end
    end

    // Nothing moves while reset is held.
    if (!reset) begin
      pc_en     = 1'b0;
      pc_sel    = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      ifid_clr  = 1'b0;
      idex_clr  = 1'b0;
      exmem_clr = 1'b0;
      memwb_clr = 1'b0;
    end
  end

  assign timeout_d = timeout_q | (freeze & (wait_d == WAIT_LIM));
  assign stall_d   = sat_inc(stall_q, stall_inc);
  assign flush_d   = sat_inc(flush_q, flush_inc);

  // State, wait counter, sticky timeout and performance counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign hz.PC_En        = pc_en;
  assign hz.PC_SelBranch = pc_sel;
  assign hz.IFID_En      = ifid_en;
  assign hz.IDEX_En      = idex_en;
  assign hz.EXMEM_En     = exmem_en;
  assign hz.MEMWB_En     = memwb_en;
  assign hz.IFID_Clr     = ifid_clr;
  assign hz.IDEX_Clr     = idex_clr;
  assign hz.EXMEM_Clr    = exmem_clr;
  assign hz.MEMWB_Clr    = memwb_clr;
  assign hz.MemTimeout   = timeout_q;
  assign hz.StallCount   = stall_q;
  assign hz.FlushCount   = flush_q;
  assign hz.State        = state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline. Drives the write-enable and clear (bubble) controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard classes: memory-wait freeze, taken-branch flush (branch resolved at MEM from the EX/MEM Condition bit) and load-use stall.
- Keeps saturating stall/flush performance counters and a memory-timeout flag.

Parameters:
- REG_ADDR_W, 5, register-specifier width
- CNT_W, 16, performance-counter width
- WAIT_MAX, 15, MEM_WAIT cycles before MemTimeout sets

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ID_Rs  in  REG_ADDR_W  source register A of the instruction in ID
- ID_Rt  in  REG_ADDR_W  source register B of the instruction in ID
- ID_UsesRs  in  1  ID instruction reads Rs
- ID_UsesRt  in  1  ID instruction reads Rt
- EX_Dest  in  REG_ADDR_W  destination register of the instruction in EX
- EX_IsLoad  in  1  instruction in EX is a load
- MEM_IsBranch  in  1  instruction in MEM is a branch or jump
- MEM_Condition  in  1  branch taken (EX/MEM Condition)
- MEM_Req  in  1  MEM stage is issuing a data-memory access
- MEM_Ready  in  1  data memory completes the access this cycle
- PC_En  out  1  PC load enable
- PC_SelBranch  out  1  PC mux selects the branch target
- IFID_En, IDEX_En, EXMEM_En, MEMWB_En  out  1 each  pipeline-register write enables
- IFID_Clr, IDEX_Clr, EXMEM_Clr, MEMWB_Clr  out  1 each  synchronous clear to NOP; has priority over En at the register
- MemTimeout  out  1  sticky flag: memory wait exceeded WAIT_MAX
- StallCount  out  CNT_W  stall cycles seen, saturating
- FlushCount  out  CNT_W  taken-branch flushes seen, saturating
- State  out  2  00 = RUN, 01 = MEM_WAIT

Behaviour:
- Control outputs are combinational (Mealy) from State and inputs, so they take effect in the same cycle. State, counters and flags are registered.
- Defaults: every En = 1, every Clr = 0, PC_SelBranch = 0.
- Reset low, asynchronously:
  - State = RUN; counters, wait counter and MemTimeout = 0.
  - While reset is held low, all En = 0 and all Clr = 0.
- Hazard detection:
  - memwait = MEM_Req & !MEM_Ready.
  - taken = MEM_IsBranch & MEM_Condition.
  - loaduse = EX_IsLoad & (EX_Dest != 0) & ((ID_UsesRs & ID_Rs == EX_Dest) | (ID_UsesRt & ID_Rt == EX_Dest)).
- RUN, evaluated in strict priority order:
  1. memwait:
     - Freeze: PC_En, IFID_En, IDEX_En, EXMEM_En = 0; MEMWB_Clr = 1.
     - Go to MEM_WAIT; wait counter = 1.
     - Branch and load-use checks are suppressed this cycle.
  2. taken:
     - PC_En = 1, PC_SelBranch = 1.
     - IFID_Clr, IDEX_Clr, EXMEM_Clr = 1 (flushes 3 younger instructions).
     - The MEM instruction itself proceeds to WB.
     - FlushCount += 1. loaduse is ignored.
  3. loaduse:
     - PC_En = 0, IFID_En = 0, IDEX_Clr = 1 (one bubble).
     - EX/MEM and MEM/WB advance.
     - Lasts exactly 1 cycle, because the load then leaves EX.
  4. Otherwise: defaults.
- MEM_WAIT:
  - If !MEM_Ready: keep the freeze outputs; wait counter += 1, saturating at WAIT_MAX. When the counter reaches WAIT_MAX, set MemTimeout. Keep waiting; there is no abort.
  - If MEM_Ready: apply RUN priorities 2–4 in the same cycle (a taken branch in MEM flushes on release) and return to RUN. No freeze that cycle.
- StallCount += 1 on every cycle with a memory freeze or a load-use stall. A flush cycle is not a stall.
- Both counters saturate at 2^CNT_W − 1 and never wrap.
- MemTimeout clears only on reset.
- Reset asserted mid-wait or mid-stall: immediate return to RUN with counters zeroed. No residual freeze after release.

Test Plan:
- Load r5 in EX, ID reads Rs = 5, UsesRs = 1 -> one cycle of PC_En = 0, IFID_En = 0, IDEX_Clr = 1; next cycle defaults; StallCount = 1. Repeat with EX_Dest = 0 -> no stall.
- MEM_Req = 1, MEM_Ready low for 3 cycles, then high -> freeze for 3 cycles with MEMWB_Clr = 1 and State = 01; release cycle shows defaults; StallCount = 3.
- Taken branch in MEM while loaduse is also true -> IFID_Clr, IDEX_Clr, EXMEM_Clr = 1, PC_SelBranch = 1, PC_En = 1; FlushCount = 1, StallCount unchanged.
- Taken branch held in MEM during a memory wait -> no flush while frozen; flush asserted in the MEM_Ready cycle only; FlushCount = 1.
- MEM_Ready held low for 20 cycles (WAIT_MAX = 15) -> MemTimeout rises after the 15th wait cycle and stays high after the wait ends. Then pull reset low mid-wait -> State = 00, counters = 0, MemTimeout = 0 asynchronously.
- CNT_W = 4, 20 load-use stalls -> StallCount holds at 15 and does not wrap.
